// File: rtl/rom_seq_pkg.sv
// Shared definitions for the ROM sequential reader: default widths and FSM state type.
package rom_seq_pkg;

    localparam int DEF_ADDR_W     = 3;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/rom_rd_fifo.sv
// Small synchronous FIFO that buffers ROM read data ahead of the output stream.
// A push and a pop in the same cycle both take effect and leave the count unchanged.
module rom_rd_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [DATA_W-1:0]            i_push_data,
    input  logic                         i_pop,
    output logic [DATA_W-1:0]            o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_C) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign w_pop   = i_pop && (r_count != '0);
    // The upstream issue rule prevents overflow; the guard only protects storage if misused.
    assign w_push  = i_push && ((r_count != DEPTH_C) || w_pop);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rom_seq_reader.sv
// Sequencer in front of the 8x8 block-ROM wrapper: reads a run of consecutive
// words (address wraps modulo ROM depth), hides the 1-cycle ROM latency with a
// FIFO and streams the words out on valid/ready while summing them.
//
//  state | meaning
//  IDLE  | waiting for start; captures base/len and clears checksum
//  READ  | issuing ROM reads while words remain and the FIFO has room
//  DRAIN | all reads returned; waiting for the FIFO to empty
//  DONE  | one-cycle completion pulse
module rom_seq_reader
    import rom_seq_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              rom_cs,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] checksum
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] FILL_MAX = (CNT_W + 1)'(FIFO_DEPTH);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_inflight;
    logic [DATA_W-1:0] r_checksum;

    logic              w_accept;
    logic              w_issue;
    logic              w_pop;
    logic              w_has_room;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_fill;
    logic [DATA_W-1:0] w_head;

    // Words already buffered plus the one the ROM is still returning must fit in the FIFO.
    assign w_fill     = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_has_room = (w_fill < FILL_MAX);
    assign w_pop      = out_valid && out_ready;

    assign rom_cs    = w_issue;
    assign rom_addr  = r_cur_addr;
    assign busy      = (r_state == READ) || (r_state == DRAIN);
    assign done      = (r_state == DONE);
    assign out_valid = (w_count != '0);
    assign out_data  = w_head;
    assign checksum  = r_checksum;

    rom_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (rom_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, start acceptance and read-issue decisions.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = (len != '0) ? READ : DONE;
                end
            end
            READ: begin
                w_issue = (r_remaining != '0) && w_has_room;
                if ((r_remaining == '0) && !r_inflight) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_count == '0) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Run parameters, in-flight tracking and checksum of delivered words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_checksum  <= '0;
        end else begin
            if (w_accept) begin
                r_cur_addr  <= base_addr;
                r_remaining <= len;
                r_checksum  <= '0;
            end else begin
                if (w_issue) begin
                    r_cur_addr  <= r_cur_addr + ADDR_W'(1);
                    r_remaining <= r_remaining - (ADDR_W + 1)'(1);
                end
                if (w_pop) begin
                    r_checksum <= r_checksum + out_data;
                end
            end
            r_inflight <= w_issue;
        end
    end

endmodule

// File: tb/tb_rom_seq_reader.sv
// Scoreboard bench for rom_seq_reader: stimulus pushes expected addresses,
// words and checksums computed from the ROM contents; a negedge monitor
// compares them against what the DUT presents.
module tb_rom_seq_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] base_addr = '0;
    logic [3:0] len = '0;
    logic       busy;
    logic       done;
    logic       rom_cs;
    logic [2:0] rom_addr;
    logic [7:0] rom_data = '0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] checksum;

    rom_seq_reader #(
        .ADDR_W     (3),
        .DATA_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rom_cs    (rom_cs),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    // ROM wrapper model: registered output, one cycle after chip-select.
    logic [7:0] rom_mem [8];
    always @(posedge clk) begin
        if (rom_cs) rom_data <= rom_mem[rom_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cs_cnt   = 0;
    int pop_cnt  = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

    logic [2:0] exp_addr[$];
    logic [7:0] exp_data[$];
    logic [7:0] exp_ck[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic report_fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Downstream ready generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: checks every issued address, delivered word and completion checksum.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rom_cs) begin
                cs_cnt++;
                if (exp_addr.size() != 0) check("rom_addr", rom_addr, exp_addr.pop_front());
                else report_fail("rom_cs_unexpected", rom_cs, 0);
            end
            if (out_valid && out_ready) begin
                pop_cnt++;
                if (exp_data.size() != 0) check("out_data", out_data, exp_data.pop_front());
                else report_fail("word_unexpected", out_data, 0);
            end
            if (done) begin
                check("words_left_at_done", exp_data.size(), 0);
                if (exp_ck.size() != 0) check("checksum_at_done", checksum, exp_ck.pop_front());
                else report_fail("done_unexpected", done, 0);
            end
        end
    end

    task automatic rom_fill_ramp();
        for (int a = 0; a < 8; a++) rom_mem[a] = 8'(8'h10 + a);
    endtask

    // Drive one start pulse and record what the run must produce.
    task automatic start_run(input int b, input int l);
        logic [7:0] sum;
        int a;
        sum = '0;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 3'(b);
        len       = 4'(l);
        for (int i = 0; i < l; i++) begin
            a = (b + i) % 8;
            exp_addr.push_back(3'(a));
            exp_data.push_back(rom_mem[a]);
            sum = sum + rom_mem[a];
        end
        exp_ck.push_back(sum);
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = 3'($urandom);
        len       = 4'($urandom);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            report_fail("done_timeout", done, 1);
        end else begin
            @(negedge clk);
            check("done_one_cycle", done, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_done"},      done, 0);
        check({tag, "_rom_cs"},    rom_cs, 0);
        check({tag, "_rom_addr"},  rom_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"},  out_data, 0);
        check({tag, "_checksum"},  checksum, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        int psnap;
        bit reached;

        rom_fill_ramp();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Full run with latency and throughput checks.
        ready_mode = 0;
        snap = cs_cnt;
        start_run(0, 8);
        @(negedge clk);
        check("lat_rom_cs_e0", rom_cs, 1);
        check("lat_busy_e0", busy, 1);
        check("lat_valid_e0", out_valid, 0);
        @(negedge clk);
        check("lat_valid_e1", out_valid, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("stream_valid", out_valid, 1);
        end
        wait_done(50);
        check("full_checksum", checksum, 8'h9C);
        check("full_cs_count", cs_cnt - snap, 8);

        // Wrap-around.
        start_run(6, 4);
        wait_done(50);
        check("wrap_checksum", checksum, 8'h4E);

        // Backpressure: reads stall once the FIFO plus in-flight word reaches depth.
        ready_mode = 2;
        repeat (2) @(posedge clk);
        snap = cs_cnt;
        start_run(0, 8);
        repeat (10) @(negedge clk);
        #1;
        check("bp_cs_before_stall", cs_cnt - snap, 4);
        check("bp_head_hold", out_data, 8'h10);
        check("bp_valid_hold", out_valid, 1);
        ready_mode = 0;
        wait_done(60);
        check("bp_checksum", checksum, 8'h9C);
        check("bp_cs_total", cs_cnt - snap, 8);

        // Zero length.
        snap = cs_cnt;
        start_run(5, 0);
        @(negedge clk);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_rom_cs", rom_cs, 0);
        @(negedge clk);
        check("zero_done_end", done, 0);
        check("zero_busy_after", busy, 0);
        check("zero_checksum", checksum, 0);
        check("zero_cs_count", cs_cnt - snap, 0);

        // Start while busy must be ignored.
        snap = cs_cnt;
        start_run(0, 8);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; base_addr = 3'd3; len = 4'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(60);
        check("busy_start_checksum", checksum, 8'h9C);
        check("busy_start_cs_count", cs_cnt - snap, 8);

        // Reset mid-run after three words delivered.
        psnap = pop_cnt;
        start_run(0, 8);
        reached = 1'b0;
        for (int k = 0; k < 40 && !reached; k++) begin
            @(negedge clk);
            #2;
            if (pop_cnt - psnap >= 3) reached = 1'b1;
        end
        if (!reached) report_fail("midrun_wait_timeout", pop_cnt - psnap, 3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun");
        exp_addr.delete();
        exp_data.delete();
        exp_ck.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_run(2, 2);
        wait_done(40);
        check("after_reset_checksum", checksum, 8'h25);

        // Randomized runs with random ROM contents and random backpressure.
        for (int r = 0; r < 24; r++) begin
            for (int a = 0; a < 8; a++) rom_mem[a] = 8'($urandom);
            ready_mode = 1;
            start_run($urandom_range(7), $urandom_range(8));
            wait_done(300);
        end
        ready_mode = 0;
        repeat (3) @(posedge clk);
        check("final_addr_queue_empty", exp_addr.size(), 0);
        check("final_ck_queue_empty", exp_ck.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
